// File: rtl/strip_pkg.sv
// Shared types for the LED strip effect blocks: mode encodings, FSM states and GRB word helpers.
package strip_pkg;

  localparam int unsigned GRB_W = 24;

  typedef enum logic [1:0] {
    MODE_FLOW   = 2'd0,
    MODE_FROZEN = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    WAIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic logic [GRB_W-1:0] grb_pack(input logic [7:0] g, input logic [7:0] r,
                                                 input logic [7:0] b);
    return {g, r, b};
  endfunction

  function automatic grb_t grb_unpack(input logic [GRB_W-1:0] w);
    return grb_t'(w);
  endfunction

endpackage

// File: rtl/hue_wheel.sv
// Combinational hue wheel: position on a HUE_STEPS-long R->G->B->R ramp to a 24-bit GRB word.
module hue_wheel
  import strip_pkg::*;
#(
  parameter int unsigned HUE_STEPS = 768,
  parameter int unsigned LOC_W     = (HUE_STEPS > 1) ? $clog2(HUE_STEPS) : 1
) (
  input  logic [LOC_W-1:0] i_loc,
  output logic [GRB_W-1:0] o_grb_c
);

  localparam int unsigned SEG_LEN = HUE_STEPS / 3;

  logic [31:0] w_loc;
  logic [31:0] w_seg;
  logic [31:0] w_ofs;
  logic [7:0]  w_v;
  logic [7:0]  w_inv;

  // Constant divisors only; synthesis folds these into shift/add networks.
  always_comb begin
    w_loc = 32'(i_loc);
    w_seg = w_loc / SEG_LEN;
    w_ofs = w_loc % SEG_LEN;
    w_v   = 8'((w_ofs << 8) / SEG_LEN);
    w_inv = 8'd255 - w_v;
    case (w_seg)
      32'd0:   o_grb_c = grb_pack(w_v, w_inv, 8'd0);
      32'd1:   o_grb_c = grb_pack(w_inv, 8'd0, w_v);
      default: o_grb_c = grb_pack(8'd0, w_v, w_inv);
    endcase
  end

endmodule

// File: rtl/strip_pattern_gen.sv
// Frame-based GRB pixel stream generator for addressable LED strips with rainbow/solid/off modes.
module strip_pattern_gen
  import strip_pkg::*;
#(
  parameter int unsigned N_LED     = 60,
  parameter int unsigned HUE_STEPS = 768,
  parameter int unsigned LED_STEP  = 13,
  parameter int unsigned PHASE_DIV = 2,
  localparam int unsigned ADDR_W   = (N_LED > 1) ? $clog2(N_LED) : 1,
  localparam int unsigned PH_W     = (HUE_STEPS > 1) ? $clog2(HUE_STEPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [GRB_W-1:0]  solid_color,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [GRB_W-1:0]  pix_data,
  output logic              pix_last,
  input  logic              frame_done,
  output logic [PH_W-1:0]   phase
);

  localparam int unsigned FC_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  state_e             r_state, w_state_nxt;
  mode_e              r_mode_sh, w_mode_sh_nxt;
  logic               r_dir_sh, w_dir_sh_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [PH_W-1:0]    r_loc, w_loc_nxt;
  logic [PH_W-1:0]    r_phase, w_phase_nxt;
  logic [FC_W-1:0]    r_frame_cnt, w_frame_cnt_nxt;
  logic               r_pix_valid, w_pix_valid_nxt;
  logic               r_pix_last, w_pix_last_nxt;
  logic [GRB_W-1:0]   r_pix_data, w_pix_data_nxt;

  logic               w_xfer;
  logic [ADDR_W-1:0]  w_addr_inc;
  logic [PH_W:0]      w_loc_sum;
  logic [PH_W-1:0]    w_loc_step;
  logic [PH_W-1:0]    w_hue_loc;
  logic [PH_W-1:0]    w_phase_step;
  logic [GRB_W-1:0]   w_hue_grb;
  logic [GRB_W-1:0]   w_pix_sel;

  assign w_xfer     = r_pix_valid & pix_ready;
  assign w_addr_inc = r_addr + ADDR_W'(1);

  // Next LED hue position: one add and a single conditional wrap.
  always_comb begin
    w_loc_sum  = (PH_W+1)'(r_loc) + (PH_W+1)'(LED_STEP);
    w_loc_step = (w_loc_sum >= (PH_W+1)'(HUE_STEPS))
               ? PH_W'(w_loc_sum - (PH_W+1)'(HUE_STEPS))
               : PH_W'(w_loc_sum);
    w_hue_loc  = (r_state == LOAD) ? r_phase : w_loc_step;
  end

  always_comb begin
    if (r_dir_sh) begin
      w_phase_step = (r_phase == '0) ? PH_W'(HUE_STEPS - 1) : r_phase - PH_W'(1);
    end else begin
      w_phase_step = (r_phase == PH_W'(HUE_STEPS - 1)) ? '0 : r_phase + PH_W'(1);
    end
  end

  hue_wheel #(
    .HUE_STEPS (HUE_STEPS),
    .LOC_W     (PH_W)
  ) u_hue (
    .i_loc   (w_hue_loc),
    .o_grb_c (w_hue_grb)
  );

  always_comb begin
    case (r_mode_sh)
      MODE_SOLID: w_pix_sel = solid_color;
      MODE_OFF:   w_pix_sel = '0;
      default:    w_pix_sel = w_hue_grb;
    endcase
  end

  // Next-state and datapath updates; the pixel word is precomputed one cycle ahead.
  always_comb begin
    w_state_nxt     = r_state;
    w_mode_sh_nxt   = r_mode_sh;
    w_dir_sh_nxt    = r_dir_sh;
    w_addr_nxt      = r_addr;
    w_loc_nxt       = r_loc;
    w_phase_nxt     = r_phase;
    w_frame_cnt_nxt = r_frame_cnt;
    w_pix_valid_nxt = r_pix_valid;
    w_pix_last_nxt  = r_pix_last;
    w_pix_data_nxt  = r_pix_data;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt   = LOAD;
          w_mode_sh_nxt = mode_e'(mode);
          w_dir_sh_nxt  = dir;
        end
      end
      LOAD: begin
        w_state_nxt     = STREAM;
        w_addr_nxt      = '0;
        w_loc_nxt       = r_phase;
        w_pix_valid_nxt = 1'b1;
        w_pix_last_nxt  = (N_LED == 1);
        w_pix_data_nxt  = w_pix_sel;
      end
      STREAM: begin
        if (w_xfer) begin
          if (r_pix_last) begin
            w_state_nxt     = WAIT;
            w_pix_valid_nxt = 1'b0;
            w_pix_last_nxt  = 1'b0;
          end else begin
            w_addr_nxt     = w_addr_inc;
            w_loc_nxt      = w_loc_step;
            w_pix_data_nxt = w_pix_sel;
            w_pix_last_nxt = (w_addr_inc == ADDR_W'(N_LED - 1));
          end
        end
      end
      WAIT: begin
        if (frame_done) begin
          if (r_mode_sh == MODE_FLOW) begin
            if (r_frame_cnt == FC_W'(PHASE_DIV - 1)) begin
              w_frame_cnt_nxt = '0;
              w_phase_nxt     = w_phase_step;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + FC_W'(1);
            end
          end
          if (enable) begin
            w_state_nxt   = LOAD;
            w_mode_sh_nxt = mode_e'(mode);
            w_dir_sh_nxt  = dir;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_sh   <= MODE_FLOW;
      r_dir_sh    <= 1'b0;
      r_addr      <= '0;
      r_loc       <= '0;
      r_phase     <= '0;
      r_frame_cnt <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_pix_data  <= '0;
    end else begin
      r_mode_sh   <= w_mode_sh_nxt;
      r_dir_sh    <= w_dir_sh_nxt;
      r_addr      <= w_addr_nxt;
      r_loc       <= w_loc_nxt;
      r_phase     <= w_phase_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      r_pix_last  <= w_pix_last_nxt;
      r_pix_data  <= w_pix_data_nxt;
    end
  end

  assign pix_valid = r_pix_valid;
  assign pix_addr  = r_addr;
  assign pix_data  = r_pix_data;
  assign pix_last  = r_pix_last;
  assign phase     = r_phase;

endmodule

// File: tb/tb_strip_pattern_gen.sv
// Bench for strip_pattern_gen: frame-level reference model plus a per-cycle output checker.
module tb_strip_pattern_gen;

  localparam int unsigned N  = 4;
  localparam int unsigned HS = 768;
  localparam int unsigned ST = 13;
  localparam int unsigned PD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic        dir;
  logic [23:0] solid_color;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [1:0]  pix_addr;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        frame_done;
  logic [9:0]  phase;

  always #5 clk = ~clk;

  strip_pattern_gen #(
    .N_LED     (N),
    .HUE_STEPS (HS),
    .LED_STEP  (ST),
    .PHASE_DIV (PD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .dir         (dir),
    .solid_color (solid_color),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .frame_done  (frame_done),
    .phase       (phase)
  );

  typedef struct {
    logic [1:0] md;
    int         ph;
  } frame_t;

  frame_t      fq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          idx = 0;
  int          frames_seen = 0;
  logic [23:0] obs [N];
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [1:0]  cur_mode = 2'd0;
  logic        cur_dir = 1'b0;
  bit          rand_ready = 1'b0;

  function automatic logic [23:0] hue_ref(input int loc);
    int s, seg, o, v;
    s   = HS / 3;
    seg = loc / s;
    o   = loc - seg * s;
    v   = (o * 256) / s;
    case (seg)
      0:       return {8'(v), 8'(255 - v), 8'h00};
      1:       return {8'(255 - v), 8'h00, 8'(v)};
      default: return {8'h00, 8'(v), 8'(255 - v)};
    endcase
  endfunction

  function automatic logic [23:0] exp_pix(input frame_t f, input int i);
    case (f.md)
      2'd2:    return solid_color;
      2'd3:    return 24'h0;
      default: return hue_ref((f.ph + i * ST) % HS);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle checker against the frame queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      fq.delete();
      idx = 0;
    end else if (pix_valid === 1'b1) begin
      if (fq.size() == 0) begin
        chk("unexpected_valid", 32'(pix_valid), 32'd0);
      end else begin
        chk("addr", 32'(pix_addr), 32'(idx));
        chk("last", 32'(pix_last), 32'(idx == N - 1));
        chk("data", 32'(pix_data), 32'(exp_pix(fq[0], idx)));
        if (idx == 0) chk("frame_phase", 32'(phase), 32'(fq[0].ph));
        if (pix_ready === 1'b1) begin
          obs[idx] = pix_data;
          if (idx == N - 1) begin
            idx = 0;
            void'(fq.pop_front());
            frames_seen++;
          end else begin
            idx++;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    pix_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [1:0] md);
    frame_t f;
    f.md = md;
    f.ph = m_phase;
    fq.push_back(f);
  endtask

  task automatic model_step();
    if (cur_mode == 2'd0) begin
      m_cnt++;
      if (m_cnt == PD) begin
        m_cnt   = 0;
        m_phase = cur_dir ? (m_phase + HS - 1) % HS : (m_phase + 1) % HS;
      end
    end
  endtask

  task automatic start_frame(input logic [1:0] md, input logic dr);
    mode = md; dir = dr; enable = 1'b1;
    push_frame(md);
    cur_mode = md; cur_dir = dr;
    tick();
    chk("load_no_valid", 32'(pix_valid), 32'd0);
    tick();
    chk("first_valid", 32'(pix_valid), 32'd1);
  endtask

  task automatic wait_frame();
    int target;
    int k;
    target = frames_seen + 1;
    k = 0;
    while (frames_seen < target && k < 200) begin
      tick();
      k++;
    end
    if (frames_seen < target) chk("frame_timeout", 32'(frames_seen), 32'(target));
    else chk("valid_after_last", 32'(pix_valid), 32'd0);
  endtask

  task automatic boundary(input logic en, input logic [1:0] md, input logic dr);
    model_step();
    mode = md; dir = dr; enable = en; frame_done = 1'b1;
    if (en) push_frame(md);
    cur_mode = md; cur_dir = dr;
    tick();
    frame_done = 1'b0;
    chk("phase_upd", 32'(phase), 32'(m_phase));
    chk("load_no_valid", 32'(pix_valid), 32'd0);
    if (en) begin
      tick();
      chk("first_valid", 32'(pix_valid), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ph_saved;
    bit seen767;
    int k;
    seen767 = 1'b0;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; dir = 1'b0;
    frame_done = 1'b0; solid_color = 24'h123456;
    repeat (3) tick();
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_addr",  32'(pix_addr),  32'd0);
    chk("rst_data",  32'(pix_data),  32'd0);
    chk("rst_last",  32'(pix_last),  32'd0);
    chk("rst_phase", 32'(phase),     32'd0);
    reset = 1'b0;
    tick();

    // First frame at phase 0
    start_frame(2'd0, 1'b0);
    wait_frame();
    chk("f0_pix0", 32'(obs[0]), 32'h00FF00);
    chk("f0_pix1", 32'(obs[1]), 32'h0DF200);
    chk("f0_pix2", 32'(obs[2]), 32'h1AE500);
    chk("f0_pix3", 32'(obs[3]), 32'h27D800);

    // Two frame_done pulses advance phase to 1
    boundary(1'b1, 2'd0, 1'b0);
    wait_frame();
    boundary(1'b1, 2'd0, 1'b0);
    chk("phase_one", 32'(phase), 32'd1);
    wait_frame();
    chk("f2_pix0", 32'(obs[0]), 32'h01FE00);

    // Reverse through 0 -> 767 down to 760
    for (k = 0; k < 40 && m_phase != 760; k++) begin
      boundary(1'b1, 2'd0, 1'b1);
      if (m_phase == 767 && !seen767) begin
        seen767 = 1'b1;
        chk("rev_wrap_767", 32'(phase), 32'd767);
      end
      wait_frame();
    end
    chk("p760_pix0", 32'(obs[0]), 32'h00F807);
    chk("p760_pix1", 32'(obs[1]), 32'h05FA00);

    // Backpressure, plus a stray frame_done while streaming
    rand_ready = 1'b1;
    boundary(1'b1, 2'd0, 1'b0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    wait_frame();
    repeat (2) begin
      boundary(1'b1, 2'd0, 1'b0);
      wait_frame();
    end
    rand_ready = 1'b0;

    // Solid colour for six frames: phase frozen
    boundary(1'b1, 2'd2, 1'b0);
    ph_saved = m_phase;
    wait_frame();
    chk("solid_pix2", 32'(obs[2]), 32'h123456);
    repeat (5) begin
      boundary(1'b1, 2'd2, 1'b0);
      wait_frame();
    end
    boundary(1'b1, 2'd0, 1'b0);
    chk("solid_phase_frozen", 32'(phase), 32'(ph_saved));

    // Mode change mid-frame applies next frame; enable drop completes frame
    tick();
    mode = 2'd3;
    wait_frame();
    boundary(1'b1, 2'd3, 1'b0);
    tick();
    enable = 1'b0;
    wait_frame();
    chk("off_pix1", 32'(obs[1]), 32'h000000);
    boundary(1'b0, 2'd3, 1'b0);
    repeat (3) tick();
    chk("idle_no_valid", 32'(pix_valid), 32'd0);

    // Reset in the middle of a frame
    start_frame(2'd0, 1'b0);
    k = 0;
    while (!(pix_valid === 1'b1 && pix_addr == 2'd2) && k < 20) begin
      tick();
      k++;
    end
    chk("reach_addr2", 32'(pix_addr), 32'd2);
    reset = 1'b1; enable = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_phase", 32'(phase),     32'd0);
    chk("mid_rst_addr",  32'(pix_addr),  32'd0);
    chk("mid_rst_last",  32'(pix_last),  32'd0);
    reset = 1'b0;
    m_phase = 0;
    m_cnt = 0;
    tick();
    start_frame(2'd0, 1'b0);
    wait_frame();
    chk("post_rst_pix0", 32'(obs[0]), 32'h00FF00);
    chk("post_rst_pix3", 32'(obs[3]), 32'h27D800);

    boundary(1'b0, 2'd0, 1'b0);
    tick();
    chk("queue_drained", 32'(fq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/strip_pattern_gen.md
# strip_pattern_gen

Parametrised pixel-stream generator for addressable RGB LED strips, successor to the fixed 60-LED / 768-step flowing-rainbow block. It produces one frame of N_LED 24-bit GRB words per refresh over a valid/ready stream into the strip serialiser, then waits for the serialiser's latch-done pulse. On a programmable frame cadence it advances an animation phase in either direction. It adds runtime mode select: flowing rainbow, frozen rainbow, solid colour or off.

## Interface

- N_LED, 60: LEDs per frame (1..1023)
- HUE_STEPS, 768: hue-wheel length; multiple of 3, ≤ 4095
- LED_STEP, 13: hue increment between adjacent LEDs; < HUE_STEPS
- PHASE_DIV, 2: frames per phase step (≥ 1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  start/continue frame generation
- mode  in  2  0 flow, 1 frozen rainbow, 2 solid, 3 off (all-zero pixels)
- dir  in  1  0 phase increments, 1 phase decrements
- solid_color  in  24  GRB word used in mode 2
- pix_valid  out  1  pixel word available
- pix_ready  in  1  serialiser accepts word
- pix_addr  out  clog2(N_LED)  LED index of current word
- pix_data  out  24  GRB word {G,R,B}
- pix_last  out  1  high with pixel N_LED-1
- frame_done  in  1  one-cycle pulse: serialiser finished latch/reset gap
- phase  out  clog2(HUE_STEPS)  current animation phase (debug)

## Operation

- FSM states: IDLE, LOAD, STREAM, WAIT.
- IDLE: pix_valid=0. enable=1 → LOAD. mode and dir are sampled into shadow registers here and held for the whole frame.
- LOAD (1 cycle): addr←0, loc←phase. → STREAM.
- STREAM: pix_valid=1. On a transfer (pix_valid & pix_ready):
  - addr increments.
  - loc←loc+LED_STEP, minus HUE_STEPS if ≥ HUE_STEPS. Single conditional subtract, no multiplier.
  - Transfer with pix_last → WAIT.
- WAIT: pix_valid=0. A frame_done pulse updates the frame counter, then → LOAD if enable, else IDLE.
  - frame_done outside WAIT is ignored.
- Phase update, shadow mode 0 only:
  - frame_cnt counts 0..PHASE_DIV-1. On wrap, phase steps ±1 modulo HUE_STEPS.
  - Forward: HUE_STEPS-1 → 0. Reverse: 0 → HUE_STEPS-1.
  - Modes 1–3 freeze both phase and frame_cnt.
- Pixel data by shadow mode:
  - mode 0/1: hue_wheel(loc).
  - mode 2: solid_color.
  - mode 3: 24'h0.
- Hue wheel: S=HUE_STEPS/3, seg=loc/S, o=loc mod S, v=(o·256)/S truncated to 8 bits.
  - seg0: R=255−v, G=v, B=0.
  - seg1: G=255−v, B=v, R=0.
  - seg2: B=255−v, R=v, G=0.
- enable dropping mid-frame does not abort the frame: the current frame completes, then the FSM goes to IDLE.
- Stall: pix_addr, pix_data and pix_last hold stable while pix_valid & !pix_ready.

## Timing

- Reset (synchronous, next edge) forces:
  - state=IDLE, pix_valid=0, pix_addr=0, pix_data=0, pix_last=0.
  - phase=0, frame_cnt=0, loc=0.
- Reset mid-frame discards the partial frame. The first frame after reset starts at phase 0.
- enable high → first pix_valid 2 cycles later (IDLE→LOAD→STREAM).
- pix_data is registered: it is valid in the same cycle as pix_valid. With pix_ready held high, throughput is 1 word/cycle.
- Last transfer → pix_valid low on the next cycle.
- frame_done in WAIT → phase is updated and LOAD is entered on the next edge. The new frame is first visible 2 cycles after frame_done.

## Structure

- Package strip_pkg holds:
  - mode encodings (MODE_FLOW, MODE_FROZEN, MODE_SOLID, MODE_OFF);
  - FSM state enum;
  - GRB pack/unpack helpers.
- Sub-module hue_wheel (parameter HUE_STEPS): combinational loc → 24-bit GRB. Reusable by other effect blocks.
- Top module holds the FSM, address/loc accumulators, phase/frame counters and the output registers.

## Test plan

- Use N_LED=4, HUE_STEPS=768, LED_STEP=13, PHASE_DIV=2, mode 0, dir 0, pix_ready=1.
  - Frame 0 must produce 0x00FF00, 0x0DF200, 0x1AE500, 0x27D800 at addr 0..3.
  - pix_last must be high only at addr 3.
- Same config, 2 frame_done pulses: phase reaches 1. Frame 2, pixel 0 = 0x01FE00.
- Wrap: force phase=760 and loc accumulation.
  - Pixel 1 loc 773 → 5, data 0x05FA00.
  - dir=1 at phase 0: the step yields phase 767.
- Backpressure: toggle pix_ready randomly.
  - addr/data/last hold during stalls.
  - Exactly 4 transfers per frame, in order.
- Mode 2 with solid_color 0x123456: all pixels 0x123456, phase frozen across 6 frames. Mode 3: all pixels 0.
  - mode written mid-frame takes effect only from the next frame.
- Reset asserted at addr 2 mid-frame: next cycle pix_valid=0 and phase=0; the first post-reset frame restarts at addr 0.
